// File: rtl/ifmap_pkg.sv
// Shared ifmap definitions: write-side FSM states and default geometry
// common to the write deserializer and the read address generator.
package ifmap_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } ifmap_state_t;

    localparam int IFMAP_DATA_WIDTH      = 16;
    localparam int IFMAP_COUNT           = 4;
    localparam int IFMAP_BANK_ADDR_WIDTH = 8;

endpackage

// File: rtl/ifmap_lane_packer.sv
// Lane counter plus pack register: gathers COUNT words into one entry and
// strobes full on the push that completes it.
module ifmap_lane_packer
    import ifmap_pkg::*;
#(
    parameter int DATA_WIDTH = IFMAP_DATA_WIDTH,
    parameter int COUNT      = IFMAP_COUNT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic                        full,
    output logic [DATA_WIDTH*COUNT-1:0] packed_data
);

    localparam int LANE_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [LANE_W-1:0] lane_reg;
    logic              last_lane;
    logic              push_ok;

    assign push_ok   = push & ~clear;
    assign last_lane = (lane_reg == LANE_W'(COUNT - 1));
    assign full      = push_ok & last_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= '0;
        end else if (clear) begin
            lane_reg <= '0;
        end else if (push_ok) begin
            lane_reg <= last_lane ? '0 : lane_reg + LANE_W'(1);
        end
    end

    // The word arriving this cycle is forwarded into its lane so the
    // completed entry is available on the same edge that accepts it.
    genvar gi;
    generate
        for (gi = 0; gi < COUNT; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] word_reg;
            logic                  hit;

            assign hit = push_ok & (lane_reg == LANE_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (clear) begin
                    word_reg <= '0;
                end else if (hit) begin
                    word_reg <= data;
                end
            end

            assign packed_data[gi*DATA_WIDTH +: DATA_WIDTH] = hit ? data : word_reg;
        end
    endgenerate

endmodule

// File: rtl/ifmap_wr_deserializer.sv
// Packs a narrow ifmap word stream into bank-wide entries, writes one tile
// into the write-side bank, then holds off until the banks are swapped.
module ifmap_wr_deserializer
    import ifmap_pkg::*;
#(
    parameter int DATA_WIDTH      = IFMAP_DATA_WIDTH,
    parameter int COUNT           = IFMAP_COUNT,
    parameter int BANK_ADDR_WIDTH = IFMAP_BANK_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        config_en,
    input  logic [BANK_ADDR_WIDTH-1:0]  config_data,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        wen,
    output logic [BANK_ADDR_WIDTH-1:0]  wadr,
    output logic [DATA_WIDTH*COUNT-1:0] wdata,
    output logic                        tile_done,
    input  logic                        swap
);

    ifmap_state_t state_reg, state_next;

    logic [BANK_ADDR_WIDTH-1:0]  entries_m1_reg;
    logic [BANK_ADDR_WIDTH-1:0]  entry_cnt_reg, entry_cnt_next;
    logic                        in_ready_reg;
    logic                        wen_reg, wen_next;
    logic                        tile_done_reg, tile_done_next;
    logic [BANK_ADDR_WIDTH-1:0]  wadr_reg;
    logic [DATA_WIDTH*COUNT-1:0] wdata_reg;

    logic                        push;
    logic                        full;
    logic [DATA_WIDTH*COUNT-1:0] packed_data;

    // in_ready_reg is high exactly while in FILL, so it doubles as the
    // state qualifier for a transfer.
    assign push = in_valid & in_ready_reg & ~config_en;

    ifmap_lane_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT      (COUNT)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .clear       (config_en),
        .data        (in_data),
        .full        (full),
        .packed_data (packed_data)
    );

    always_comb begin
        state_next     = state_reg;
        entry_cnt_next = entry_cnt_reg;
        wen_next       = 1'b0;
        tile_done_next = 1'b0;
        if (config_en) begin
            state_next     = FILL;
            entry_cnt_next = '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (full) begin
                        wen_next = 1'b1;
                        if (entry_cnt_reg == entries_m1_reg) begin
                            tile_done_next = 1'b1;
                            entry_cnt_next = '0;
                            state_next     = WAIT_SWAP;
                        end else begin
                            entry_cnt_next = entry_cnt_reg + BANK_ADDR_WIDTH'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (swap) begin
                        state_next = FILL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            entries_m1_reg <= '0;
            entry_cnt_reg  <= '0;
            in_ready_reg   <= 1'b0;
            wen_reg        <= 1'b0;
            tile_done_reg  <= 1'b0;
            wadr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            entry_cnt_reg <= entry_cnt_next;
            in_ready_reg  <= (state_next == FILL);
            wen_reg       <= wen_next;
            tile_done_reg <= tile_done_next;
            if (config_en) begin
                entries_m1_reg <= config_data;
            end
            if (wen_next) begin
                wadr_reg  <= entry_cnt_reg;
                wdata_reg <= packed_data;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign wen       = wen_reg;
    assign wadr      = wadr_reg;
    assign wdata     = wdata_reg;
    assign tile_done = tile_done_reg;

endmodule
